// File: rtl/el2_lsu_ecc_scrub.sv
// DCCM ECC scrubber: queues corrected data for R-stage single-bit errors and writes it back
// through the LSU arbiter, dropping entries made stale by newer stores/DMA; keeps SEC/DED counters.
module el2_lsu_ecc_scrub #(
  parameter int DCCM_BITS       = 16,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int SCRUB_DEPTH     = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       dec_tlu_core_ecc_disable,
  input  logic                       lsu_single_ecc_error_r,
  input  logic                       single_ecc_error_lo_r,
  input  logic                       single_ecc_error_hi_r,
  input  logic                       lsu_double_ecc_error_r,
  input  logic [DCCM_BITS-1:0]       lsu_addr_r,
  input  logic [DCCM_BITS-1:0]       end_addr_r,
  input  logic [DCCM_DATA_WIDTH-1:0] sec_data_lo_r,
  input  logic [DCCM_DATA_WIDTH-1:0] sec_data_hi_r,
  input  logic                       stbuf_wen,
  input  logic [DCCM_BITS-1:0]       stbuf_waddr_lo,
  input  logic [DCCM_BITS-1:0]       stbuf_waddr_hi,
  input  logic                       dma_dccm_wen,
  input  logic [DCCM_BITS-1:0]       dma_waddr,
  input  logic                       scrub_gnt,
  output logic                       scrub_req,
  output logic                       scrub_wen_lo,
  output logic                       scrub_wen_hi,
  output logic [DCCM_BITS-1:0]       scrub_waddr_lo,
  output logic [DCCM_BITS-1:0]       scrub_waddr_hi,
  output logic [DCCM_DATA_WIDTH-1:0] scrub_wdata_lo,
  output logic [DCCM_DATA_WIDTH-1:0] scrub_wdata_hi,
  output logic                       scrub_full,
  output logic                       scrub_pending,
  output logic                       scrub_overflow,
  output logic [CNT_WIDTH-1:0]       ecc_sec_count,
  output logic [CNT_WIDTH-1:0]       ecc_ded_count,
  input  logic                       ecc_cnt_clr
);

  localparam int AW = $clog2(SCRUB_DEPTH);
  localparam int WW = DCCM_BITS - 2;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                     state;
  logic [AW:0]                wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [AW-1:0]              wr_idx, rd_idx;
  logic [SCRUB_DEPTH-1:0]     lo_v, hi_v, lo_v_nxt, hi_v_nxt;
  logic [SCRUB_DEPTH-1:0]     lo_hit, hi_hit;
  logic [WW-1:0]              lo_word [SCRUB_DEPTH];
  logic [WW-1:0]              hi_word [SCRUB_DEPTH];
  logic [DCCM_DATA_WIDTH-1:0] lo_data [SCRUB_DEPTH];
  logic [DCCM_DATA_WIDTH-1:0] hi_data [SCRUB_DEPTH];
  logic [WW-1:0]              st_lo_word, st_hi_word, dma_word;
  logic                       capture, push, pop, drop, q_full, full_nxt;
  logic                       wen_lo_raw, wen_hi_raw;
  logic                       unused_addr_bits;

  assign unused_addr_bits = ^{lsu_addr_r[1:0], end_addr_r[1:0], stbuf_waddr_lo[1:0],
                              stbuf_waddr_hi[1:0], dma_waddr[1:0]};

  assign st_lo_word = stbuf_waddr_lo[DCCM_BITS-1:2];
  assign st_hi_word = stbuf_waddr_hi[DCCM_BITS-1:2];
  assign dma_word   = dma_waddr[DCCM_BITS-1:2];

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign q_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A newer store or DMA write to the same word makes any queued correction stale.
  always_comb begin
    lo_hit = '0;
    hi_hit = '0;
    for (int i = 0; i < SCRUB_DEPTH; i++) begin
      lo_hit[i] = (stbuf_wen && ((st_lo_word == lo_word[i]) || (st_hi_word == lo_word[i]))) ||
                  (dma_dccm_wen && (dma_word == lo_word[i]));
      hi_hit[i] = (stbuf_wen && ((st_lo_word == hi_word[i]) || (st_hi_word == hi_word[i]))) ||
                  (dma_dccm_wen && (dma_word == hi_word[i]));
    end
  end

  assign wen_lo_raw = (state == REQ) && lo_v[rd_idx] && !lo_hit[rd_idx];
  assign wen_hi_raw = (state == REQ) && hi_v[rd_idx] && !hi_hit[rd_idx];

  // A head with nothing left to write never requests and retires immediately.
  assign scrub_req    = wen_lo_raw || wen_hi_raw;
  assign scrub_wen_lo = wen_lo_raw;
  assign scrub_wen_hi = wen_hi_raw;

  assign scrub_waddr_lo = scrub_req ? {lo_word[rd_idx], 2'b00} : '0;
  assign scrub_waddr_hi = scrub_req ? {hi_word[rd_idx], 2'b00} : '0;
  assign scrub_wdata_lo = scrub_req ? lo_data[rd_idx] : '0;
  assign scrub_wdata_hi = scrub_req ? hi_data[rd_idx] : '0;

  assign capture = lsu_single_ecc_error_r && !lsu_double_ecc_error_r && !dec_tlu_core_ecc_disable;
  assign pop     = (state == REQ) && (scrub_gnt || !scrub_req);
  assign push    = capture && (!q_full || pop);
  assign drop    = capture && q_full && !pop;

  assign wr_ptr_nxt = wr_ptr + (AW+1)'(push);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);
  assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

  always_comb begin
    lo_v_nxt = lo_v & ~lo_hit;
    hi_v_nxt = hi_v & ~hi_hit;
    if (push) begin
      lo_v_nxt[wr_idx] = single_ecc_error_lo_r;
      hi_v_nxt[wr_idx] = single_ecc_error_hi_r;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      lo_v           <= '0;
      hi_v           <= '0;
      scrub_full     <= 1'b0;
      scrub_pending  <= 1'b0;
      scrub_overflow <= 1'b0;
      ecc_sec_count  <= '0;
      ecc_ded_count  <= '0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      lo_v          <= lo_v_nxt;
      hi_v          <= hi_v_nxt;
      state         <= (wr_ptr_nxt != rd_ptr_nxt) ? REQ : IDLE;
      scrub_pending <= (wr_ptr_nxt != rd_ptr_nxt);
      scrub_full    <= full_nxt;
      if (ecc_cnt_clr) begin
        ecc_sec_count  <= '0;
        ecc_ded_count  <= '0;
        scrub_overflow <= 1'b0;
      end else begin
        if (capture && (ecc_sec_count != '1))
          ecc_sec_count <= ecc_sec_count + 1'b1;
        if (lsu_double_ecc_error_r && !dec_tlu_core_ecc_disable && (ecc_ded_count != '1))
          ecc_ded_count <= ecc_ded_count + 1'b1;
        if (drop)
          scrub_overflow <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; it is only observed through valid head entries.
  always_ff @(posedge clk) begin
    if (push) begin
      lo_word[wr_idx] <= lsu_addr_r[DCCM_BITS-1:2];
      hi_word[wr_idx] <= end_addr_r[DCCM_BITS-1:2];
      lo_data[wr_idx] <= sec_data_lo_r;
      hi_data[wr_idx] <= sec_data_hi_r;
    end
  end

endmodule

// File: tb/tb_el2_lsu_ecc_scrub.sv
// Bench for el2_lsu_ecc_scrub: directed scenarios plus random traffic, all checked against
// a queue-based reference model of the scrubber.
module tb_el2_lsu_ecc_scrub;

  localparam int DB    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          dec_tlu_core_ecc_disable;
  logic          lsu_single_ecc_error_r, single_ecc_error_lo_r, single_ecc_error_hi_r;
  logic          lsu_double_ecc_error_r;
  logic [DB-1:0] lsu_addr_r, end_addr_r;
  logic [DW-1:0] sec_data_lo_r, sec_data_hi_r;
  logic          stbuf_wen;
  logic [DB-1:0] stbuf_waddr_lo, stbuf_waddr_hi;
  logic          dma_dccm_wen;
  logic [DB-1:0] dma_waddr;
  logic          scrub_gnt;
  logic          scrub_req, scrub_wen_lo, scrub_wen_hi;
  logic [DB-1:0] scrub_waddr_lo, scrub_waddr_hi;
  logic [DW-1:0] scrub_wdata_lo, scrub_wdata_hi;
  logic          scrub_full, scrub_pending, scrub_overflow;
  logic [CW-1:0] ecc_sec_count, ecc_ded_count;
  logic          ecc_cnt_clr;

  always #5 clk = ~clk;

  el2_lsu_ecc_scrub #(
    .DCCM_BITS(DB), .DCCM_DATA_WIDTH(DW), .SCRUB_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .dec_tlu_core_ecc_disable(dec_tlu_core_ecc_disable),
    .lsu_single_ecc_error_r(lsu_single_ecc_error_r),
    .single_ecc_error_lo_r(single_ecc_error_lo_r),
    .single_ecc_error_hi_r(single_ecc_error_hi_r),
    .lsu_double_ecc_error_r(lsu_double_ecc_error_r),
    .lsu_addr_r(lsu_addr_r), .end_addr_r(end_addr_r),
    .sec_data_lo_r(sec_data_lo_r), .sec_data_hi_r(sec_data_hi_r),
    .stbuf_wen(stbuf_wen), .stbuf_waddr_lo(stbuf_waddr_lo), .stbuf_waddr_hi(stbuf_waddr_hi),
    .dma_dccm_wen(dma_dccm_wen), .dma_waddr(dma_waddr),
    .scrub_gnt(scrub_gnt), .scrub_req(scrub_req),
    .scrub_wen_lo(scrub_wen_lo), .scrub_wen_hi(scrub_wen_hi),
    .scrub_waddr_lo(scrub_waddr_lo), .scrub_waddr_hi(scrub_waddr_hi),
    .scrub_wdata_lo(scrub_wdata_lo), .scrub_wdata_hi(scrub_wdata_hi),
    .scrub_full(scrub_full), .scrub_pending(scrub_pending), .scrub_overflow(scrub_overflow),
    .ecc_sec_count(ecc_sec_count), .ecc_ded_count(ecc_ded_count),
    .ecc_cnt_clr(ecc_cnt_clr)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          lo_v;
    bit          hi_v;
    int          lo_w;
    int          hi_w;
    logic [31:0] lo_d;
    logic [31:0] hi_d;
  } ent_t;

  ent_t q[$];
  int   m_sec;
  int   m_ded;
  bit   m_ovf;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit killed(int w);
    bit k;
    k = 1'b0;
    if (stbuf_wen && ((int'(stbuf_waddr_lo) >> 2) == w || (int'(stbuf_waddr_hi) >> 2) == w)) k = 1'b1;
    if (dma_dccm_wen && (int'(dma_waddr) >> 2) == w) k = 1'b1;
    return k;
  endfunction

  function automatic bit effLo();
    return q.size() > 0 && q[0].lo_v && !killed(q[0].lo_w);
  endfunction

  function automatic bit effHi();
    return q.size() > 0 && q[0].hi_v && !killed(q[0].hi_w);
  endfunction

  task automatic modelReset();
    q.delete();
    m_sec = 0;
    m_ded = 0;
    m_ovf = 1'b0;
  endtask

  task automatic checkAll(input string ph);
    bit elo, ehi, ereq;
    elo  = effLo();
    ehi  = effHi();
    ereq = elo || ehi;
    checkOutput({ph, ".req"},     32'(scrub_req),      32'(ereq));
    checkOutput({ph, ".wen_lo"},  32'(scrub_wen_lo),   32'(elo));
    checkOutput({ph, ".wen_hi"},  32'(scrub_wen_hi),   32'(ehi));
    checkOutput({ph, ".addr_lo"}, 32'(scrub_waddr_lo), ereq ? 32'(q[0].lo_w * 4) : 32'h0);
    checkOutput({ph, ".addr_hi"}, 32'(scrub_waddr_hi), ereq ? 32'(q[0].hi_w * 4) : 32'h0);
    checkOutput({ph, ".data_lo"}, scrub_wdata_lo,      ereq ? q[0].lo_d : 32'h0);
    checkOutput({ph, ".data_hi"}, scrub_wdata_hi,      ereq ? q[0].hi_d : 32'h0);
    checkOutput({ph, ".full"},    32'(scrub_full),     32'(q.size() == DEPTH));
    checkOutput({ph, ".pending"}, 32'(scrub_pending),  32'(q.size() != 0));
    checkOutput({ph, ".ovf"},     32'(scrub_overflow), 32'(m_ovf));
    checkOutput({ph, ".sec"},     32'(ecc_sec_count),  32'(m_sec));
    checkOutput({ph, ".ded"},     32'(ecc_ded_count),  32'(m_ded));
  endtask

  // One clock of the reference: retire the head, invalidate stale halves, then accept the capture.
  task automatic modelStep();
    bit   cap, req, dropped;
    ent_t e;
    cap     = lsu_single_ecc_error_r && !lsu_double_ecc_error_r && !dec_tlu_core_ecc_disable;
    req     = effLo() || effHi();
    dropped = 1'b0;
    if (q.size() > 0 && (!req || scrub_gnt)) void'(q.pop_front());
    foreach (q[i]) begin
      if (killed(q[i].lo_w)) q[i].lo_v = 1'b0;
      if (killed(q[i].hi_w)) q[i].hi_v = 1'b0;
    end
    if (cap) begin
      if (q.size() < DEPTH) begin
        e.lo_v = single_ecc_error_lo_r;
        e.hi_v = single_ecc_error_hi_r;
        e.lo_w = int'(lsu_addr_r) >> 2;
        e.hi_w = int'(end_addr_r) >> 2;
        e.lo_d = sec_data_lo_r;
        e.hi_d = sec_data_hi_r;
        q.push_back(e);
      end else begin
        dropped = 1'b1;
      end
    end
    if (ecc_cnt_clr) begin
      m_sec = 0;
      m_ded = 0;
      m_ovf = 1'b0;
    end else begin
      if (cap && m_sec < CMAX) m_sec++;
      if (lsu_double_ecc_error_r && !dec_tlu_core_ecc_disable && m_ded < CMAX) m_ded++;
      if (dropped) m_ovf = 1'b1;
    end
  endtask

  task automatic applyStimulus(input string ph);
    @(negedge clk);
    checkAll(ph);
    @(posedge clk);
    if (rst_l) modelStep();
    #1;
  endtask

  task automatic idleInputs();
    dec_tlu_core_ecc_disable = 1'b0;
    lsu_single_ecc_error_r   = 1'b0;
    single_ecc_error_lo_r    = 1'b0;
    single_ecc_error_hi_r    = 1'b0;
    lsu_double_ecc_error_r   = 1'b0;
    lsu_addr_r               = '0;
    end_addr_r               = '0;
    sec_data_lo_r            = '0;
    sec_data_hi_r            = '0;
    stbuf_wen                = 1'b0;
    stbuf_waddr_lo           = '0;
    stbuf_waddr_hi           = '0;
    dma_dccm_wen             = 1'b0;
    dma_waddr                = '0;
    scrub_gnt                = 1'b0;
    ecc_cnt_clr              = 1'b0;
  endtask

  task automatic setSec(input logic lo, input logic hi, input logic [15:0] a, input logic [15:0] ea,
                        input logic [31:0] dlo, input logic [31:0] dhi);
    lsu_single_ecc_error_r = lo | hi;
    single_ecc_error_lo_r  = lo;
    single_ecc_error_hi_r  = hi;
    lsu_addr_r             = a;
    end_addr_r             = ea;
    sec_data_lo_r          = dlo;
    sec_data_hi_r          = dhi;
  endtask

  task automatic clearCounters(input string ph);
    idleInputs();
    ecc_cnt_clr = 1'b1;
    applyStimulus(ph);
    idleInputs();
  endtask

  function automatic logic [15:0] rndAddr();
    return 16'h0100 + 16'($urandom_range(0, 31));
  endfunction

  initial begin
    idleInputs();
    modelReset();
    rst_l = 1'b0;
    @(negedge clk);
    checkAll("reset");
    @(posedge clk);
    #1;
    rst_l = 1'b1;

    // Lo-only correction held off by the arbiter for three cycles.
    clearCounters("t1clr");
    setSec(1'b1, 1'b0, 16'h0104, 16'h0104, 32'hDEADBEEF, 32'h0);
    applyStimulus("t1cap");
    idleInputs();
    #1;
    checkOutput("t1_req",     32'(scrub_req), 32'h1);
    checkOutput("t1_wen_lo",  32'(scrub_wen_lo), 32'h1);
    checkOutput("t1_wen_hi",  32'(scrub_wen_hi), 32'h0);
    checkOutput("t1_addr_lo", 32'(scrub_waddr_lo), 32'h0104);
    checkOutput("t1_data_lo", scrub_wdata_lo, 32'hDEADBEEF);
    checkOutput("t1_sec",     32'(ecc_sec_count), 32'h1);
    repeat (3) applyStimulus("t1wait");
    scrub_gnt = 1'b1;
    applyStimulus("t1gnt");
    scrub_gnt = 1'b0;
    #1;
    checkOutput("t1_pend", 32'(scrub_pending), 32'h0);

    // Dual-bank correction retired by a single grant.
    clearCounters("t2clr");
    setSec(1'b1, 1'b1, 16'h0106, 16'h0109, 32'hA5A5A5A5, 32'h5A5A5A5A);
    applyStimulus("t2cap");
    idleInputs();
    #1;
    checkOutput("t2_addr_lo", 32'(scrub_waddr_lo), 32'h0104);
    checkOutput("t2_addr_hi", 32'(scrub_waddr_hi), 32'h0108);
    checkOutput("t2_wen_lo",  32'(scrub_wen_lo), 32'h1);
    checkOutput("t2_wen_hi",  32'(scrub_wen_hi), 32'h1);
    scrub_gnt = 1'b1;
    applyStimulus("t2gnt");
    idleInputs();
    #1;
    checkOutput("t2_pend", 32'(scrub_pending), 32'h0);

    // Overflow, then push accepted alongside a pop from a full queue.
    clearCounters("t3clr");
    setSec(1'b1, 1'b0, 16'h0300, 16'h0300, 32'h1, 32'h0);
    applyStimulus("t3a");
    setSec(1'b1, 1'b0, 16'h0310, 16'h0310, 32'h2, 32'h0);
    applyStimulus("t3b");
    #1;
    checkOutput("t3_full", 32'(scrub_full), 32'h1);
    setSec(1'b1, 1'b0, 16'h0320, 16'h0320, 32'h3, 32'h0);
    applyStimulus("t3c");
    #1;
    checkOutput("t3_ovf", 32'(scrub_overflow), 32'h1);
    checkOutput("t3_sec", 32'(ecc_sec_count), 32'h3);
    setSec(1'b1, 1'b0, 16'h0330, 16'h0330, 32'h4, 32'h0);
    scrub_gnt = 1'b1;
    applyStimulus("t3d");
    idleInputs();
    #1;
    checkOutput("t3_full2",  32'(scrub_full), 32'h1);
    checkOutput("t3_addr_lo", 32'(scrub_waddr_lo), 32'h0310);
    scrub_gnt = 1'b1;
    repeat (3) applyStimulus("t3drain");
    idleInputs();

    // Store and DMA kills.
    clearCounters("t4clr");
    setSec(1'b1, 1'b0, 16'h0200, 16'h0200, 32'h11111111, 32'h0);
    applyStimulus("t4cap");
    idleInputs();
    stbuf_wen      = 1'b1;
    stbuf_waddr_lo = 16'h0202;
    #1;
    checkOutput("t4_req_killed", 32'(scrub_req), 32'h0);
    applyStimulus("t4kill");
    idleInputs();
    #1;
    checkOutput("t4_pend", 32'(scrub_pending), 32'h0);
    setSec(1'b1, 1'b0, 16'h0200, 16'h0200, 32'h22222222, 32'h0);
    applyStimulus("t4cap2");
    idleInputs();
    applyStimulus("t4hold");
    dma_dccm_wen = 1'b1;
    dma_waddr    = 16'h0200;
    scrub_gnt    = 1'b1;
    #1;
    checkOutput("t4_dma_wen_lo", 32'(scrub_wen_lo), 32'h0);
    applyStimulus("t4dma");
    idleInputs();
    repeat (2) applyStimulus("t4idle");
    #1;
    checkOutput("t4_pend2", 32'(scrub_pending), 32'h0);

    // DED suppresses capture; disable freezes counters.
    clearCounters("t5clr");
    setSec(1'b1, 1'b0, 16'h0500, 16'h0500, 32'h5, 32'h0);
    lsu_double_ecc_error_r = 1'b1;
    applyStimulus("t5ded");
    idleInputs();
    #1;
    checkOutput("t5_ded",  32'(ecc_ded_count), 32'h1);
    checkOutput("t5_sec",  32'(ecc_sec_count), 32'h0);
    checkOutput("t5_pend", 32'(scrub_pending), 32'h0);
    dec_tlu_core_ecc_disable = 1'b1;
    setSec(1'b1, 1'b0, 16'h0504, 16'h0504, 32'h6, 32'h0);
    applyStimulus("t5dis_sec");
    lsu_double_ecc_error_r = 1'b1;
    applyStimulus("t5dis_ded");
    idleInputs();
    #1;
    checkOutput("t5_ded2",  32'(ecc_ded_count), 32'h1);
    checkOutput("t5_sec2",  32'(ecc_sec_count), 32'h0);
    checkOutput("t5_pend2", 32'(scrub_pending), 32'h0);

    // Counter saturation, clear, and reset while a request is outstanding.
    clearCounters("t6clr");
    lsu_double_ecc_error_r = 1'b1;
    repeat (CMAX + 2) applyStimulus("t6ded");
    idleInputs();
    #1;
    checkOutput("t6_ded_sat", 32'(ecc_ded_count), 32'(CMAX));
    setSec(1'b1, 1'b0, 16'h0600, 16'h0600, 32'h66, 32'h0);
    scrub_gnt = 1'b1;
    repeat (CMAX + 2) applyStimulus("t6sec");
    idleInputs();
    #1;
    checkOutput("t6_sec_sat", 32'(ecc_sec_count), 32'(CMAX));
    scrub_gnt = 1'b1;
    repeat (2) applyStimulus("t6drain");
    idleInputs();
    setSec(1'b1, 1'b0, 16'h0700, 16'h0700, 32'h77, 32'h0);
    repeat (3) applyStimulus("t6fill");
    idleInputs();
    #1;
    checkOutput("t6_ovf", 32'(scrub_overflow), 32'h1);
    ecc_cnt_clr = 1'b1;
    applyStimulus("t6clr2");
    idleInputs();
    #1;
    checkOutput("t6_ovf_clr", 32'(scrub_overflow), 32'h0);
    checkOutput("t6_sec_clr", 32'(ecc_sec_count), 32'h0);
    checkOutput("t6_ded_clr", 32'(ecc_ded_count), 32'h0);
    checkOutput("t6_req_held", 32'(scrub_req), 32'h1);
    rst_l = 1'b0;
    #1;
    modelReset();
    checkOutput("t6_rst_req",     32'(scrub_req), 32'h0);
    checkOutput("t6_rst_wen_lo",  32'(scrub_wen_lo), 32'h0);
    checkOutput("t6_rst_addr_lo", 32'(scrub_waddr_lo), 32'h0);
    checkOutput("t6_rst_data_lo", scrub_wdata_lo, 32'h0);
    checkOutput("t6_rst_full",    32'(scrub_full), 32'h0);
    checkOutput("t6_rst_pend",    32'(scrub_pending), 32'h0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    applyStimulus("t6post");
    #1;
    checkOutput("t6_post_pend", 32'(scrub_pending), 32'h0);

    // Random traffic over a small address window so stores and DMA collide with queued words.
    for (int c = 0; c < 600; c++) begin
      bit lo, hi;
      idleInputs();
      if ($urandom_range(0, 2) == 0) begin
        lo = 1'($urandom_range(0, 1));
        hi = 1'($urandom_range(0, 1));
        if (!lo && !hi) lo = 1'b1;
        setSec(lo, hi, rndAddr(), rndAddr(), $urandom, $urandom);
      end
      lsu_double_ecc_error_r   = ($urandom_range(0, 9) == 0);
      dec_tlu_core_ecc_disable = ($urandom_range(0, 15) == 0);
      stbuf_wen                = ($urandom_range(0, 5) == 0);
      stbuf_waddr_lo           = rndAddr();
      stbuf_waddr_hi           = rndAddr();
      dma_dccm_wen             = ($urandom_range(0, 7) == 0);
      dma_waddr                = rndAddr();
      scrub_gnt                = 1'($urandom_range(0, 1));
      ecc_cnt_clr              = ($urandom_range(0, 39) == 0);
      applyStimulus("rnd");
    end
    idleInputs();
    applyStimulus("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/el2_lsu_ecc_scrub.md
Name: el2_lsu_ecc_scrub

Overview:
- Sits directly downstream of the LSU ECC detect/correct stage.
- On every R-stage single-bit DCCM error, captures the corrected data for each failing bank (lo/hi) plus its bank word address into a small queue.
- Issues correction write-backs to the DCCM through the LSU write arbiter, and drops stale entries when a newer store hits the same word.
- Keeps saturating SEC/DED event counters and a sticky overflow flag for the TLU.

Parameters:
- DCCM_BITS, 16: DCCM byte-address width.
- DCCM_DATA_WIDTH, 32: data width per bank.
- SCRUB_DEPTH, 2: queue entries (power of 2, ≥2).
- CNT_WIDTH, 16: width of each event counter.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  asynchronous, active-low reset.
- dec_tlu_core_ecc_disable  in  1  blocks new captures and counter updates.
- lsu_single_ecc_error_r  in  1  R-stage correctable error, OR of both banks.
- single_ecc_error_lo_r  in  1  lo-bank SEC.
- single_ecc_error_hi_r  in  1  hi-bank SEC.
- lsu_double_ecc_error_r  in  1  R-stage uncorrectable error.
- lsu_addr_r  in  DCCM_BITS  start address; selects the lo-bank word.
- end_addr_r  in  DCCM_BITS  end address; selects the hi-bank word.
- sec_data_lo_r  in  DCCM_DATA_WIDTH  corrected lo data.
- sec_data_hi_r  in  DCCM_DATA_WIDTH  corrected hi data.
- stbuf_wen  in  1  store-buffer DCCM write this cycle.
- stbuf_waddr_lo  in  DCCM_BITS  store lo-bank address.
- stbuf_waddr_hi  in  DCCM_BITS  store hi-bank address.
- dma_dccm_wen  in  1  DMA DCCM write this cycle.
- dma_waddr  in  DCCM_BITS  DMA write address.
- scrub_gnt  in  1  arbiter grant; the write completes in this cycle.
- scrub_req  out  1  write-back request.
- scrub_wen_lo  out  1  write lo bank.
- scrub_wen_hi  out  1  write hi bank.
- scrub_waddr_lo  out  DCCM_BITS  lo write address, [1:0]=0.
- scrub_waddr_hi  out  DCCM_BITS  hi write address, [1:0]=0.
- scrub_wdata_lo  out  DCCM_DATA_WIDTH  lo write data; ECC is encoded externally.
- scrub_wdata_hi  out  DCCM_DATA_WIDTH  hi write data; ECC is encoded externally.
- scrub_full  out  1  queue full; the LSU stalls DCCM loads while this is set.
- scrub_pending  out  1  queue non-empty.
- scrub_overflow  out  1  sticky; set when an error is dropped because the queue is full.
- ecc_sec_count  out  CNT_WIDTH  saturating count of SEC events.
- ecc_ded_count  out  CNT_WIDTH  saturating count of DED events.
- ecc_cnt_clr  in  1  synchronous clear of both counters and the overflow flag.

Behaviour:
- Reset (async, rst_l=0):
  - Queue empty; all entry valids 0.
  - scrub_req, scrub_wen_*, scrub_full, scrub_pending, scrub_overflow = 0.
  - Counters = 0; addr/data outputs = 0.
  - Reset mid-request aborts the request; no write is reported.
- Capture condition (cycle N): lsu_single_ecc_error_r & ~lsu_double_ecc_error_r & ~dec_tlu_core_ecc_disable.
- Capture action: push one entry with
  - lo_v = single_ecc_error_lo_r, lo_addr = {lsu_addr_r[DCCM_BITS-1:2], 2'b0}, lo_data;
  - hi_v = single_ecc_error_hi_r, hi_addr = {end_addr_r[DCCM_BITS-1:2], 2'b0}, hi_data.
- Queue is a circular FIFO with wr/rd pointers of log2(SCRUB_DEPTH)+1 bits. Full = MSBs differ and LSBs are equal; empty = pointers equal.
- Entry latency: an entry pushed in cycle N is visible at the head in N+1, so scrub_req can assert no earlier than N+1.
- FSM:
  - IDLE: go to REQ when the queue is non-empty.
  - REQ: scrub_req=1 and outputs driven from the head entry. On scrub_gnt, pop; go to IDLE if the queue is then empty, else stay in REQ.
- Write enables: scrub_wen_lo = head.lo_v & ~lo_kill; scrub_wen_hi = head.hi_v & ~hi_kill.
- Kill terms (combinational, same cycle), compared on [DCCM_BITS-1:2]:
  - lo_kill: stbuf_wen with stbuf_waddr_lo or stbuf_waddr_hi matching, or dma_dccm_wen with dma_waddr matching.
  - hi_kill: same comparison against hi_addr.
- Invalidation: every queued entry (not only the head) clears the valid bit of any half whose word matches a store/DMA write. An entry with both halves invalid is popped silently without raising scrub_req.
- Push and pop in the same cycle: pop is evaluated first, so a full queue that pops this cycle accepts the push.
- Full queue with no pop: the capture is dropped, scrub_overflow is set, and ecc_sec_count still increments.
- ecc_sec_count: +1 per cycle in which the capture condition holds.
- ecc_ded_count: +1 per cycle with lsu_double_ecc_error_r & ~dec_tlu_core_ecc_disable.
- Both counters saturate at all-ones; ecc_cnt_clr has priority over increment.
- dec_tlu_core_ecc_disable does not flush entries already queued; they still drain.
- scrub_full and scrub_pending are registered from pointer state.

Test Plan:
1. Lo-only SEC, lsu_addr_r=0x0104, sec_data_lo_r=0xDEADBEEF; hold gnt=0 for 3 cycles, then gnt=1 → scrub_req rises at N+1 with wen_lo=1, wen_hi=0, waddr_lo=0x0104, wdata_lo=0xDEADBEEF; pending drops the cycle after gnt; ecc_sec_count=1.
2. Dual-bank SEC, lsu_addr_r=0x0106, end_addr_r=0x0109 → one entry with waddr_lo=0x0104, waddr_hi=0x0108, both wen=1; a single gnt retires it.
3. Three back-to-back SECs with gnt=0 (DEPTH=2) → scrub_full=1 after two; the third is dropped; scrub_overflow=1; ecc_sec_count=3. Then gnt=1 with a simultaneous 4th SEC → the 4th is accepted and the queue stays full.
4. Queued lo entry at 0x0200, then stbuf_wen with stbuf_waddr_lo=0x0202 → entry is killed, no scrub_req is observed, pending returns to 0. DMA write to 0x0200 on the same cycle as gnt → wen_lo=0.
5. lsu_double_ecc_error_r=1 together with single=1 → no capture; ecc_ded_count=1, ecc_sec_count=0. Hold ecc_disable=1 → no counter change.
6. Preload counters to all-ones → they saturate; ecc_cnt_clr clears counters and overflow. Assert rst_l=0 while REQ is held → all outputs are 0 immediately and the queue is empty after release.
